// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car datapath and its display stages.
package elevator_pkg;

   localparam int DEF_NUM_FLOORS = 4;
   localparam int DEF_FLOOR_W    = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOVE_UP,
      ST_MOVE_DOWN,
      ST_CHECK,
      ST_DOOR_OPEN
   } state_t;

   // Active-low segments, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Binary digit to active-low 7-segment pattern; values above 9 show blank.
module seg7_decoder
   import elevator_pkg::*;
#(
   parameter int DIGIT_W = 4
)(
   input  logic [DIGIT_W-1:0] digit,
   output logic [6:0]         seg
);

   logic [31:0] digit_ext;

   assign digit_ext = 32'(digit);

   always_comb begin
      seg = SEG_BLANK;
      case (digit_ext)
         32'd0:   seg = SEG_0;
         32'd1:   seg = SEG_1;
         32'd2:   seg = SEG_2;
         32'd3:   seg = SEG_3;
         32'd4:   seg = SEG_4;
         32'd5:   seg = SEG_5;
         32'd6:   seg = SEG_6;
         32'd7:   seg = SEG_7;
         32'd8:   seg = SEG_8;
         32'd9:   seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/elevator_car_sequencer.sv
// Car travel and door sequencing driven by the floor-request comparator;
// owns the car position and the floor digit shown on HEX0.
module elevator_car_sequencer
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
   parameter int FLOOR_W     = DEF_FLOOR_W,
   parameter int FLOOR_TICKS = 50_000_000,
   parameter int DOOR_TICKS  = 150_000_000
)(
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               up,
   input  logic               down,
   input  logic               complete,
   input  logic               door_sensor,
   input  logic               door_open_req,
   output logic [FLOOR_W-1:0] actual_floor,
   output logic               motor_up,
   output logic               motor_down,
   output logic               door_open,
   output logic               arrived,
   output logic               busy,
   output logic [6:0]         HEX0
);

   localparam int                 TIMER_W      = $clog2(max_int(FLOOR_TICKS, DOOR_TICKS));
   localparam logic [TIMER_W-1:0] FLOOR_RELOAD = TIMER_W'(FLOOR_TICKS - 1);
   localparam logic [TIMER_W-1:0] DOOR_RELOAD  = TIMER_W'(DOOR_TICKS - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(NUM_FLOORS - 1);

   state_t             state_reg;
   logic [TIMER_W-1:0] timer_reg;
   logic [FLOOR_W-1:0] floor_reg;
   logic               arrived_reg;
   logic [6:0]         hex_reg;
   logic [FLOOR_W:0]   digit_next;
   logic [6:0]         seg_next;
   logic               at_top;
   logic               at_bottom;

   assign at_top     = (floor_reg >= TOP_FLOOR);
   assign at_bottom  = (floor_reg == '0);
   assign digit_next = {1'b0, floor_reg} + 1'b1;

   seg7_decoder #(
      .DIGIT_W (FLOOR_W + 1)
   ) u_seg7 (
      .digit (digit_next),
      .seg   (seg_next)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         timer_reg   <= '0;
         floor_reg   <= '0;
         arrived_reg <= 1'b0;
         hex_reg     <= SEG_1;
      end else begin
         arrived_reg <= 1'b0;
         hex_reg     <= seg_next;
         case (state_reg)
            ST_IDLE: begin
               if (door_open_req) begin
                  state_reg <= ST_DOOR_OPEN;
                  timer_reg <= DOOR_RELOAD;
               end else if (up && !down && !at_top) begin
                  state_reg <= ST_MOVE_UP;
                  timer_reg <= FLOOR_RELOAD;
               end else if (down && !up && !at_bottom) begin
                  state_reg <= ST_MOVE_DOWN;
                  timer_reg <= FLOOR_RELOAD;
               end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
               if (timer_reg == '0) begin
                  // Guards keep the position saturating even if entry checks are bypassed
                  if (state_reg == ST_MOVE_UP && !at_top) begin
                     floor_reg <= floor_reg + 1'b1;
                  end else if (state_reg == ST_MOVE_DOWN && !at_bottom) begin
                     floor_reg <= floor_reg - 1'b1;
                  end
                  arrived_reg <= 1'b1;
                  state_reg   <= ST_CHECK;
               end else begin
                  timer_reg <= timer_reg - 1'b1;
               end
            end
            ST_CHECK: begin
               if (complete) begin
                  state_reg <= ST_DOOR_OPEN;
                  timer_reg <= DOOR_RELOAD;
               end else if (up && !at_top) begin
                  state_reg <= ST_MOVE_UP;
                  timer_reg <= FLOOR_RELOAD;
               end else if (down && !at_bottom) begin
                  state_reg <= ST_MOVE_DOWN;
                  timer_reg <= FLOOR_RELOAD;
               end else begin
                  state_reg <= ST_DOOR_OPEN;
                  timer_reg <= DOOR_RELOAD;
               end
            end
            ST_DOOR_OPEN: begin
               if (door_sensor || door_open_req) begin
                  timer_reg <= DOOR_RELOAD;
               end else if (timer_reg == '0) begin
                  state_reg <= ST_IDLE;
               end else begin
                  timer_reg <= timer_reg - 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign actual_floor = floor_reg;
   assign motor_up     = (state_reg == ST_MOVE_UP);
   assign motor_down   = (state_reg == ST_MOVE_DOWN);
   assign door_open    = (state_reg == ST_DOOR_OPEN);
   assign busy         = (state_reg != ST_IDLE);
   assign arrived      = arrived_reg;
   assign HEX0         = hex_reg;

endmodule

// File: tb/tb_elevator_car_sequencer.sv
// Directed and randomized checks of the car sequencer against a cycle-level
// behavioural model of travel phases and door dwell.
module tb_elevator_car_sequencer;

   localparam int NF = 4;
   localparam int FT = 4;
   localparam int DT = 3;

   localparam int M_IDLE = 0;
   localparam int M_UP   = 1;
   localparam int M_DOWN = 2;
   localparam int M_CHK  = 3;
   localparam int M_DOOR = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       up = 1'b0;
   logic       down = 1'b0;
   logic       complete = 1'b0;
   logic       door_sensor = 1'b0;
   logic       door_open_req = 1'b0;
   logic [1:0] actual_floor;
   logic       motor_up;
   logic       motor_down;
   logic       door_open;
   logic       arrived;
   logic       busy;
   logic [6:0] HEX0;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int         m_state = M_IDLE;
   int         m_floor = 0;
   int         m_left  = 0;
   bit         m_arr   = 1'b0;
   logic [6:0] m_hex   = 7'b1111001;

   always #5 clk = ~clk;

   elevator_car_sequencer #(
      .NUM_FLOORS  (NF),
      .FLOOR_W     (2),
      .FLOOR_TICKS (FT),
      .DOOR_TICKS  (DT)
   ) dut (
      .CLOCK_50      (clk),
      .reset         (reset),
      .up            (up),
      .down          (down),
      .complete      (complete),
      .door_sensor   (door_sensor),
      .door_open_req (door_open_req),
      .actual_floor  (actual_floor),
      .motor_up      (motor_up),
      .motor_down    (motor_down),
      .door_open     (door_open),
      .arrived       (arrived),
      .busy          (busy),
      .HEX0          (HEX0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   // One clock of the behavioural model; m_left counts cycles remaining in a phase.
   task automatic model_step();
      if (reset) begin
         m_state = M_IDLE;
         m_floor = 0;
         m_left  = 0;
         m_arr   = 1'b0;
         m_hex   = seg_of(1);
         return;
      end
      m_hex = seg_of(m_floor + 1);
      m_arr = 1'b0;
      case (m_state)
         M_IDLE: begin
            if (door_open_req) begin
               m_state = M_DOOR; m_left = DT;
            end else if (up && !down && m_floor < NF - 1) begin
               m_state = M_UP; m_left = FT;
            end else if (down && !up && m_floor > 0) begin
               m_state = M_DOWN; m_left = FT;
            end
         end
         M_UP, M_DOWN: begin
            m_left--;
            if (m_left == 0) begin
               m_floor = (m_state == M_UP) ? m_floor + 1 : m_floor - 1;
               m_arr   = 1'b1;
               m_state = M_CHK;
            end
         end
         M_CHK: begin
            if (complete) begin
               m_state = M_DOOR; m_left = DT;
            end else if (up && m_floor < NF - 1) begin
               m_state = M_UP; m_left = FT;
            end else if (down && m_floor > 0) begin
               m_state = M_DOWN; m_left = FT;
            end else begin
               m_state = M_DOOR; m_left = DT;
            end
         end
         default: begin
            if (door_sensor || door_open_req) begin
               m_left = DT;
            end else begin
               m_left--;
               if (m_left == 0) m_state = M_IDLE;
            end
         end
      endcase
   endtask

   task automatic compare_all();
      check("floor",      32'(actual_floor), 32'(m_floor));
      check("motor_up",   32'(motor_up),     32'(m_state == M_UP));
      check("motor_down", 32'(motor_down),   32'(m_state == M_DOWN));
      check("door_open",  32'(door_open),    32'(m_state == M_DOOR));
      check("busy",       32'(busy),         32'(m_state != M_IDLE));
      check("arrived",    32'(arrived),      32'(m_arr));
      check("hex",        32'(HEX0),         32'(m_hex));
      check("door_motor_excl", 32'(door_open & (motor_up | motor_down)), 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic wait_idle(input string tag);
      int i;
      for (i = 0; i < 50 && m_state != M_IDLE; i++) tick();
      check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int n_arr;
      int n_mu;
      int n_door;
      int cnt;

      // reset and idle
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (2) tick();
      check("rst_floor", 32'(actual_floor), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_door",  32'(door_open), 32'd0);
      check("rst_hex",   32'(HEX0), 32'h79);
      $display("txn reset: floor=%0d hex=%b", actual_floor, HEX0);

      // floor 0 -> 2 with complete on arrival
      n_arr = 0; n_mu = 0; n_door = 0;
      up = 1'b1;
      for (int i = 0; i < 40 && m_floor != 2; i++) begin
         tick();
         n_arr += int'(arrived);
         n_mu  += int'(motor_up);
      end
      up = 1'b0; complete = 1'b1;
      tick();
      n_door += int'(door_open);
      complete = 1'b0;
      for (int i = 0; i < 10 && m_state != M_IDLE; i++) begin
         tick();
         n_door += int'(door_open);
      end
      check("s1_arrivals",    32'(n_arr), 32'd2);
      check("s1_motor_cyc",   32'(n_mu), 32'd8);
      check("s1_door_cyc",    32'(n_door), 32'd3);
      check("s1_floor",       32'(actual_floor), 32'd2);
      check("s1_hex",         32'(HEX0), 32'h30);
      check("s1_busy",        32'(busy), 32'd0);
      $display("txn up0to2: arrivals=%0d motor_cycles=%0d door_cycles=%0d floor=%0d", n_arr, n_mu, n_door, actual_floor);

      // up request at the top floor is ignored
      up = 1'b1;
      for (int i = 0; i < 40 && m_floor != 3; i++) tick();
      wait_idle("s2_reach_top");
      repeat (5) tick();
      check("s2_top_busy",  32'(busy), 32'd0);
      check("s2_top_floor", 32'(actual_floor), 32'd3);
      up = 1'b0;
      $display("txn top_hold: floor=%0d busy=%0d", actual_floor, busy);

      // down request at the bottom floor is ignored
      down = 1'b1;
      for (int i = 0; i < 60 && m_floor != 0; i++) tick();
      wait_idle("s2_reach_bottom");
      repeat (5) tick();
      check("s2_bot_busy",  32'(busy), 32'd0);
      check("s2_bot_floor", 32'(actual_floor), 32'd0);
      down = 1'b0;
      $display("txn bottom_hold: floor=%0d busy=%0d", actual_floor, busy);

      // obstruction holds the door open
      door_open_req = 1'b1;
      tick();
      door_open_req = 1'b0;
      door_sensor = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("s3_hold_open", 32'(door_open), 32'd1);
      end
      door_sensor = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cnt++;
         if (!door_open) break;
      end
      check("s3_close_latency", 32'(cnt), 32'd3);
      $display("txn door_hold: close_after=%0d", cnt);

      // reversal and door requests are ignored mid-floor
      up = 1'b1;
      tick();
      up = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cnt++;
         if (i == 0) begin
            down = 1'b1; door_open_req = 1'b1;
         end else begin
            down = 1'b0; door_open_req = 1'b0;
         end
         if (arrived) break;
      end
      check("s4_travel_cycles", 32'(cnt), 32'd4);
      check("s4_floor", 32'(actual_floor), 32'd1);
      wait_idle("s4_idle");
      $display("txn ignore_mid_move: arrive_after=%0d floor=%0d", cnt, actual_floor);

      // reset while moving down from floor 2
      up = 1'b1;
      tick();
      up = 1'b0;
      wait_idle("s5_reach2");
      down = 1'b1;
      repeat (3) tick();
      check("s5_pre_floor", 32'(actual_floor), 32'd2);
      check("s5_pre_motor", 32'(motor_down), 32'd1);
      reset = 1'b1; down = 1'b0;
      tick();
      reset = 1'b0;
      check("s5_rst_floor", 32'(actual_floor), 32'd0);
      check("s5_rst_motor", 32'(motor_down), 32'd0);
      check("s5_rst_busy",  32'(busy), 32'd0);
      check("s5_rst_hex",   32'(HEX0), 32'h79);
      $display("txn reset_mid_move: floor=%0d busy=%0d", actual_floor, busy);

      // randomized traffic against the model
      for (int blk = 0; blk < 10; blk++) begin
         for (int c = 0; c < 200; c++) begin
            up            = ($urandom_range(0, 99) < 35);
            down          = ($urandom_range(0, 99) < 35);
            complete      = ($urandom_range(0, 99) < 20);
            door_sensor   = ($urandom_range(0, 99) < 8);
            door_open_req = ($urandom_range(0, 99) < 4);
            reset         = ($urandom_range(0, 999) < 5);
            tick();
         end
         $display("txn random_block %0d: floor=%0d checks=%0d", blk, actual_floor, n_checks);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
